// File: rtl/quadra_out_buf_if.sv
// Upstream (quadra side) and downstream valid/ready signals of quadra_out_buf in one bundle.
interface quadra_out_buf_if #(
   parameter int unsigned Y_W = 24
);
   logic           in_vld;
   logic           in_rdy;
   logic [Y_W-1:0] y;
   logic           out_vld;
   logic           out_rdy;
   logic [Y_W-1:0] out_y;

   // The buffer itself
   modport slave  (input in_vld, y, out_rdy, output in_rdy, out_vld, out_y);
   // Upstream producer / downstream consumer
   modport master (output in_vld, y, out_rdy, input in_rdy, out_vld, out_y);
endinterface

// File: rtl/quadra_out_buf.sv
// Output buffer behind quadra: a valid delay line matched to quadra latency feeds a FWFT FIFO.
// Upstream is throttled by credits, so every accepted sample has a FIFO slot when its y arrives.
module quadra_out_buf #(
   parameter  int unsigned Y_W   = 24,
   parameter  int unsigned LAT   = 3,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             flush,
   quadra_out_buf_if.slave  bus,
   output logic [LVL_W-1:0] level,
   output logic             err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SUM_W = LVL_W + 1;

   logic [LAT-1:0]   vld_d;
   logic [Y_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [Y_W-1:0]   out_y_q;

   logic             acc_c;
   logic             push_c;
   logic             push_ok_c;
   logic             pop_c;
   logic             full_c;
   logic [LVL_W-1:0] inflight_c;
   logic [SUM_W-1:0] credit_c;

   // Modulo-DEPTH increment; DEPTH need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Samples still inside quadra, each already holding a reserved slot
   always_comb begin
      inflight_c = '0;
      for (int i = 0; i < int'(LAT); i++) begin
         inflight_c = inflight_c + LVL_W'(vld_d[i]);
      end
   end

   assign credit_c    = SUM_W'(level) + SUM_W'(inflight_c);
   assign bus.in_rdy  = (credit_c < SUM_W'(DEPTH));
   assign bus.out_vld = (level != '0);
   assign bus.out_y   = out_y_q;

   assign acc_c     = bus.in_vld & bus.in_rdy;
   assign pop_c     = bus.out_vld & bus.out_rdy;
   assign push_c    = vld_d[LAT-1];
   assign full_c    = (level == LVL_W'(DEPTH));
   assign push_ok_c = push_c & (~full_c | pop_c);

   // Control state: delay line, pointers, occupancy, sticky overflow
   always_ff @(posedge clk) begin
      if (!rst_b || flush) begin
         vld_d  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         err    <= 1'b0;
      end else begin
         vld_d <= LAT'({vld_d, acc_c});
         if (push_ok_c) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop_c) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push_ok_c, pop_c})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (push_c && full_c && !pop_c) begin
            err <= 1'b1;
         end
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[wr_ptr] <= bus.y;
      end
   end

   // Head register: bypass y when the FIFO is (or becomes) empty, else prefetch the next entry
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         out_y_q <= '0;
      end else if (!flush) begin
         if (push_ok_c && ((level == '0) || ((level == LVL_W'(1)) && pop_c))) begin
            out_y_q <= bus.y;
         end else if (pop_c) begin
            out_y_q <= mem[ptr_inc(rd_ptr)];
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_b) !err);

endmodule

// File: tb/tb_quadra_out_buf.sv
// Bench for quadra_out_buf: quadra is modelled as a pure LAT-cycle delay of x, and the expected
// stream comes from a queue model of pending samples and buffered results.
module tb_quadra_out_buf;

   localparam int unsigned Y_W   = 24;
   localparam int unsigned LAT   = 3;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_b;
   logic             flush;
   logic [LVL_W-1:0] level;
   logic             err;

   quadra_out_buf_if #(.Y_W(Y_W)) bus ();

   quadra_out_buf #(.Y_W(Y_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .flush (flush),
      .bus   (bus),
      .level (level),
      .err   (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [Y_W-1:0] val;
      int             due;
   } pend_t;

   int             n_chk  = 0;
   int             n_pass = 0;
   int             cyc    = 0;
   int             n_acc  = 0;
   int             n_pops = 0;
   bit             m_err  = 1'b0;
   bit             chk_en = 1'b0;
   logic [Y_W-1:0] x;
   logic [Y_W-1:0] tag;
   logic [Y_W-1:0] qd [LAT];
   pend_t          pend [$];
   logic [Y_W-1:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // A slot is free when buffered plus still-in-quadra samples stay below DEPTH
   function automatic bit m_rdy();
      return (exp_q.size() + pend.size()) < int'(DEPTH);
   endfunction

   // One clock edge: update the model from the inputs of the ending cycle, then drive quadra's y
   task automatic step();
      bit    acc;
      bit    pop;
      bit    full;
      pend_t p;
      @(posedge clk);
      cyc++;
      if (!rst_b || flush) begin
         exp_q.delete();
         pend.delete();
         m_err = 1'b0;
         if (!rst_b) chk_en = 1'b1;
      end else begin
         acc  = bus.in_vld && m_rdy();
         pop  = (exp_q.size() != 0) && bus.out_rdy;
         full = (exp_q.size() == int'(DEPTH));
         if (pop) begin
            void'(exp_q.pop_front());
            n_pops++;
         end
         if (pend.size() != 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (full && !pop) m_err = 1'b1;
            else exp_q.push_back(p.val);
         end
         if (acc) begin
            pend.push_back('{x, cyc + int'(LAT)});
            n_acc++;
         end
      end
      for (int i = int'(LAT) - 1; i > 0; i--) qd[i] = qd[i-1];
      qd[0] = x;
      #1;
      bus.y = qd[LAT-1];
   endtask

   task automatic idle(input int n);
      bus.in_vld  = 1'b0;
      bus.out_rdy = 1'b1;
      flush       = 1'b0;
      repeat (n) begin
         x = Y_W'($urandom);
         step();
      end
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_rdy",  32'(bus.in_rdy),  32'(m_rdy()));
         chk("out_vld", 32'(bus.out_vld), 32'(exp_q.size() != 0));
         chk("level",   32'(level),       32'(exp_q.size()));
         chk("err",     32'(err),         32'(m_err));
         if (exp_q.size() != 0) chk("out_y", 32'(bus.out_y), 32'(exp_q[0]));
      end
   end

   initial begin
      int a0;
      int p0;
      int maxl;
      rst_b       = 1'b0;
      flush       = 1'b0;
      bus.in_vld  = 1'b1;
      bus.out_rdy = 1'b1;
      bus.y       = '0;
      x           = '0;
      tag         = Y_W'(1);
      for (int i = 0; i < int'(LAT); i++) qd[i] = '0;

      // T1: reset held two cycles with in_vld high
      step();
      @(negedge clk);
      chk("t1_out_vld", 32'(bus.out_vld), 32'd0);
      chk("t1_level",   32'(level),       32'd0);
      chk("t1_in_rdy",  32'(bus.in_rdy),  32'd1);
      chk("t1_err",     32'(err),         32'd0);
      chk("t1_out_y",   32'(bus.out_y),   32'd0);
      step();
      rst_b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         x = tag;
         tag++;
         step();
         @(negedge clk);
         chk("t1_no_push", 32'(level), 32'd0);
      end
      idle(8);

      // T2: single accept, result appears LAT+1 cycles later
      bus.in_vld = 1'b1;
      x          = 24'h00ABCD;
      step();
      bus.in_vld = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         x = Y_W'($urandom);
         @(negedge clk);
         chk("t2_out_vld", 32'(bus.out_vld), (k == 4) ? 32'd1 : 32'd0);
         if (k == 4) chk("t2_out_y", 32'(bus.out_y), 32'h00ABCD);
         step();
      end
      idle(8);

      // T3: backpressure fills exactly DEPTH slots, then drains in order
      bus.out_rdy = 1'b0;
      bus.in_vld  = 1'b1;
      tag         = Y_W'(1);
      a0          = n_acc;
      for (int c = 0; c < 20; c++) begin
         x = tag;
         tag++;
         step();
      end
      @(negedge clk);
      chk("t3_accepts", 32'(n_acc - a0), 32'd8);
      chk("t3_level",   32'(level),      32'd8);
      chk("t3_in_rdy",  32'(bus.in_rdy), 32'd0);
      chk("t3_err",     32'(err),        32'd0);
      bus.in_vld  = 1'b0;
      bus.out_rdy = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         chk("t3_drain_vld", 32'(bus.out_vld), 32'd1);
         chk("t3_drain_y",   32'(bus.out_y),   32'(k));
         step();
         @(negedge clk);
      end
      chk("t3_empty", 32'(bus.out_vld), 32'd0);
      idle(8);

      // T4: sustained streaming
      bus.in_vld  = 1'b1;
      bus.out_rdy = 1'b1;
      for (int c = 0; c < 10; c++) begin
         x = tag;
         tag++;
         step();
      end
      a0   = n_acc;
      p0   = n_pops;
      maxl = 0;
      for (int c = 0; c < 100; c++) begin
         x = tag;
         tag++;
         step();
         @(negedge clk);
         if (int'(level) > maxl) maxl = int'(level);
      end
      chk("t4_accepts",  32'(n_acc - a0),  32'd100);
      chk("t4_results",  32'(n_pops - p0), 32'd100);
      chk("t4_level_ok", 32'(maxl <= int'(LAT) + 1), 32'd1);
      idle(8);

      // T5: flush with three samples in flight
      bus.in_vld = 1'b1;
      for (int c = 0; c < 3; c++) begin
         x = tag;
         tag++;
         step();
      end
      bus.in_vld = 1'b0;
      flush      = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("t5_level",   32'(level),       32'd0);
      chk("t5_out_vld", 32'(bus.out_vld), 32'd0);
      chk("t5_in_rdy",  32'(bus.in_rdy),  32'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         @(negedge clk);
         chk("t5_no_push", 32'(level), 32'd0);
      end
      idle(8);

      // T6: random traffic, many pointer wraps
      p0 = n_pops;
      for (int c = 0; c < 10000; c++) begin
         bus.in_vld  = ($urandom_range(0, 3) != 0);
         bus.out_rdy = ($urandom_range(0, 3) != 0);
         x = tag;
         tag++;
         step();
      end
      idle(12);
      @(negedge clk);
      chk("t6_wraps", 32'((n_pops - p0) > 100 * int'(DEPTH)), 32'd1);
      chk("t6_err",   32'(err),   32'd0);
      chk("t6_level", 32'(level), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
